// File: rtl/dino_pkg.sv
// Shared types and screen-timing constants for the dino game blocks.
package dino_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } run_state_e;

  localparam int unsigned SCREEN_LINES         = 480;
  localparam int unsigned FRAME_LINES          = 525;
  localparam int unsigned FRAME_PIXELS         = 800;
  localparam int unsigned DEFAULT_TICK_LINE    = SCREEN_LINES;
  localparam int unsigned DEFAULT_LEVEL_FRAMES = 600;

endpackage

// File: rtl/game_tick_scheduler_edge_pulse.sv
// Registered rising-edge detector; RESET_VAL seeds the history so a level
// already high when reset releases does not produce a pulse.
module edge_pulse #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic hist_r;
  logic pulse_r;

  // history flop and one-cycle strobe on a 0->1 transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_r  <= RESET_VAL;
      pulse_r <= 1'b0;
    end else begin
      hist_r  <= din;
      pulse_r <= ~hist_r & din;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/game_tick_scheduler.sv
// Game-rate strobe generation from the beam position, run-state tracking
// and difficulty ramp for the dino game.
module game_tick_scheduler
  import dino_pkg::*;
#(
  parameter int unsigned TICK_LINE    = DEFAULT_TICK_LINE,
  parameter int unsigned TICK_DIV     = 3,
  parameter int unsigned LEVEL_FRAMES = DEFAULT_LEVEL_FRAMES,
  parameter int unsigned MAX_LEVEL    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       game_start_pulse,
  input  logic       game_over_pulse,
  output logic       game_tick_60hz,
  output logic [1:0] game_tick_20hz,
  output logic       obstacle_tick,
  output logic       debounce_countdown_en,
  output logic       running,
  output logic [1:0] speed_level
);

  localparam logic [9:0] TICK_LINE_C  = 10'(TICK_LINE);
  localparam logic [3:0] PHASE_LAST_C = 4'(TICK_DIV - 1);
  localparam logic [9:0] LEVEL_LAST_C = 10'(LEVEL_FRAMES - 1);
  localparam logic [1:0] MAX_LEVEL_C  = 2'(MAX_LEVEL);

  run_state_e state_r;
  run_state_e state_next_s;
  logic       line_hit_s;
  logic       level_clear_s;
  logic       run_tick_s;
  logic [3:0] phase_r;
  logic [9:0] frame_cnt_r;
  logic [1:0] level_r;
  logic       tick60_r;
  logic [1:0] tick20_r;
  logic       obstacle_r;
  logic       running_r;
  logic       debounce_s;

  assign line_hit_s = (vpos == TICK_LINE_C) && (hpos == 10'd0);

  // A start that coincides with game over is dropped entirely.
  assign level_clear_s = game_start_pulse && !game_over_pulse;
  assign run_tick_s    = line_hit_s && (state_next_s == RUNNING);

  // run-state next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (level_clear_s) begin
          state_next_s = RUNNING;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUNNING: begin
        if (game_over_pulse) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUNNING;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // frame strobe, two-phase 20 Hz strobe and obstacle strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick60_r   <= 1'b0;
      tick20_r   <= 2'b00;
      obstacle_r <= 1'b0;
      phase_r    <= 4'd0;
    end else begin
      tick60_r   <= line_hit_s;
      tick20_r   <= {tick20_r[0], line_hit_s && (phase_r == 4'd0)};
      obstacle_r <= run_tick_s;
      if (line_hit_s) begin
        phase_r <= (phase_r == PHASE_LAST_C) ? 4'd0 : phase_r + 4'd1;
      end
    end
  end

  // run state and difficulty ramp; level holds while idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      running_r   <= 1'b0;
      frame_cnt_r <= 10'd0;
      level_r     <= 2'd0;
    end else begin
      state_r   <= state_next_s;
      running_r <= (state_next_s == RUNNING);
      if (level_clear_s) begin
        frame_cnt_r <= 10'd0;
        level_r     <= 2'd0;
      end else if (run_tick_s) begin
        if (frame_cnt_r == LEVEL_LAST_C) begin
          frame_cnt_r <= 10'd0;
          if (level_r != MAX_LEVEL_C) begin
            level_r <= level_r + 2'd1;
          end
        end else begin
          frame_cnt_r <= frame_cnt_r + 10'd1;
        end
      end
    end
  end

  edge_pulse #(
    .RESET_VAL (1'b1)
  ) u_debounce_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (vpos[4]),
    .pulse (debounce_s)
  );

  assign game_tick_60hz        = tick60_r;
  assign game_tick_20hz        = tick20_r;
  assign obstacle_tick         = obstacle_r;
  assign debounce_countdown_en = debounce_s;
  assign running               = running_r;
  assign speed_level           = level_r;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Randomized bench for game_tick_scheduler against an integer-count reference model.
module tb_game_tick_scheduler;
  import dino_pkg::*;

  localparam int TL   = 480;
  localparam int DIV  = 3;
  localparam int LF   = 4;
  localparam int MAXL = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       game_start_pulse;
  logic       game_over_pulse;
  logic       game_tick_60hz;
  logic [1:0] game_tick_20hz;
  logic       obstacle_tick;
  logic       debounce_countdown_en;
  logic       running;
  logic [1:0] speed_level;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic       m_t60, m_obs, m_deb, m_run, m_prev_v4;
  logic [1:0] m_t20;
  int         m_ticks, m_frames, m_lvl;

  // observations
  int         mm_cnt = 0;
  logic [7:0] mm_got, mm_exp;
  int         obs60, obs20_0, obs20_1, obs_obs, both_hi, frame_idx;
  int         t20_frames[$];
  int         deb_lines[$];

  game_tick_scheduler #(
    .TICK_LINE    (TL),
    .TICK_DIV     (DIV),
    .LEVEL_FRAMES (LF),
    .MAX_LEVEL    (MAXL)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .hpos                  (hpos),
    .vpos                  (vpos),
    .game_start_pulse      (game_start_pulse),
    .game_over_pulse       (game_over_pulse),
    .game_tick_60hz        (game_tick_60hz),
    .game_tick_20hz        (game_tick_20hz),
    .obstacle_tick         (obstacle_tick),
    .debounce_countdown_en (debounce_countdown_en),
    .running               (running),
    .speed_level           (speed_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    obs60 = 0; obs20_0 = 0; obs20_1 = 0; obs_obs = 0; both_hi = 0;
    t20_frames.delete();
    deb_lines.delete();
  endtask

  // one clock: drive inputs, advance the model, sample outputs after the edge
  task automatic step(input logic [9:0] h, input logic [9:0] v,
                      input logic st, input logic ov, input logic rn);
    logic       hit;
    logic [7:0] got, expv;
    hpos = h; vpos = v; game_start_pulse = st; game_over_pulse = ov; rst_n = rn;
    if (!rn) begin
      m_t60 = 1'b0; m_t20 = 2'b00; m_obs = 1'b0; m_deb = 1'b0; m_run = 1'b0;
      m_ticks = 0; m_frames = 0; m_lvl = 0; m_prev_v4 = 1'b1;
    end else begin
      hit      = (int'(v) == TL) && (h == 10'd0);
      m_t20[1] = m_t20[0];
      m_t20[0] = hit && ((m_ticks % DIV) == 0);
      m_t60    = hit;
      if (hit) m_ticks++;
      m_deb     = !m_prev_v4 && v[4];
      m_prev_v4 = v[4];
      if (ov) m_run = 1'b0;
      else if (st) m_run = 1'b1;
      m_obs = hit && m_run;
      if (st && !ov) m_frames = 0;
      else if (hit && m_run) m_frames++;
      m_lvl = (m_frames / LF > MAXL) ? MAXL : m_frames / LF;
    end
    @(posedge clk);
    #1;
    game_start_pulse = 1'b0;
    game_over_pulse  = 1'b0;
    got  = {game_tick_60hz, game_tick_20hz, obstacle_tick, debounce_countdown_en, running, speed_level};
    expv = {m_t60, m_t20, m_obs, m_deb, m_run, m_lvl[1:0]};
    if (got !== expv) begin
      if (mm_cnt == 0) begin mm_got = got; mm_exp = expv; end
      mm_cnt++;
    end
    obs60   += int'(game_tick_60hz);
    obs20_0 += int'(game_tick_20hz[0]);
    obs20_1 += int'(game_tick_20hz[1]);
    obs_obs += int'(obstacle_tick);
    if (game_tick_20hz == 2'b11) both_hi++;
    if (game_tick_20hz[0] === 1'b1) t20_frames.push_back(frame_idx);
    if (debounce_countdown_en === 1'b1) deb_lines.push_back(int'(v));
  endtask

  // one compressed frame: two beam positions per line, optional pulses on one line
  task automatic run_frame(input int pulse_line, input logic st, input logic ov);
    logic [9:0] h;
    logic       fire;
    for (int v = 0; v < int'(FRAME_LINES); v++) begin
      for (int k = 0; k < 2; k++) begin
        h    = (k == 0) ? 10'd0 : 10'($urandom_range(1, FRAME_PIXELS - 1));
        fire = (v == pulse_line) && (k == 1);
        step(h, 10'(v), fire & st, fire & ov, 1'b1);
      end
    end
    frame_idx++;
  endtask

  task automatic run_lines(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      step(10'd0, 10'(v), 1'b0, 1'b0, 1'b1);
      step(10'($urandom_range(1, 799)), 10'(v), 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic check_model(input string name, input int mm0);
    n_checks++;
    if (mm_cnt != mm0) begin
      n_fail++;
      $display("FAIL %s model: %0d cycles differ, first got=%b exp=%b", name, mm_cnt - mm0, mm_got, mm_exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    for (int i = 0; i < 3; i++) step(10'd5, 10'd100, 1'b0, 1'b0, 1'b0);
    got = {game_tick_60hz, game_tick_20hz, obstacle_tick, debounce_countdown_en, running, speed_level};
    n_checks++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b", got, 8'h00);
    end
  endtask

  task automatic test_frame_tick();
    int mm0;
    mm0 = mm_cnt;
    clear_obs();
    for (int f = 0; f < 3; f++) run_frame(-1, 1'b0, 1'b0);
    n_checks++;
    if (obs60 !== 3) begin n_fail++; $display("FAIL tick60_count got=%0d exp=3", obs60); end
    n_checks++;
    if (obs20_0 !== 1 || obs20_1 !== 1) begin
      n_fail++; $display("FAIL tick20_first_frames got=%0d/%0d exp=1/1", obs20_0, obs20_1);
    end
    check_model("frame_tick", mm0);
  endtask

  task automatic test_20hz();
    int mm0;
    mm0 = mm_cnt;
    clear_obs();
    for (int f = 0; f < 9; f++) run_frame(-1, 1'b0, 1'b0);
    n_checks++;
    if (obs20_0 + obs20_1 !== 6) begin n_fail++; $display("FAIL tick20_total got=%0d exp=6", obs20_0 + obs20_1); end
    n_checks++;
    if (both_hi !== 0) begin n_fail++; $display("FAIL tick20_overlap got=%0d exp=0", both_hi); end
    n_checks++;
    if (t20_frames.size() !== 3) begin
      n_fail++; $display("FAIL tick20_pairs got=%0d exp=3", t20_frames.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (t20_frames[i] - t20_frames[i-1] !== DIV) begin
          n_fail++; $display("FAIL tick20_gap got=%0d exp=%0d", t20_frames[i] - t20_frames[i-1], DIV);
        end
      end
    end
    check_model("tick20", mm0);
  endtask

  task automatic test_debounce();
    int mm0;
    mm0 = mm_cnt;
    clear_obs();
    run_lines(0, 63);
    n_checks++;
    if (deb_lines.size() !== 2) begin
      n_fail++; $display("FAIL debounce_count got=%0d exp=2", deb_lines.size());
    end else begin
      n_checks++;
      if (deb_lines[0] !== 16 || deb_lines[1] !== 48) begin
        n_fail++; $display("FAIL debounce_lines got=%0d,%0d exp=16,48", deb_lines[0], deb_lines[1]);
      end
    end
    run_lines(0, 19);
    step(10'd0, 10'd20, 1'b0, 1'b0, 1'b0);
    step(10'd7, 10'd20, 1'b0, 1'b0, 1'b0);
    deb_lines.delete();
    run_lines(20, 63);
    n_checks++;
    if (deb_lines.size() !== 1 || deb_lines[0] !== 48) begin
      n_fail++; $display("FAIL debounce_after_reset got=%0d pulses exp=1 at 48", deb_lines.size());
    end
    check_model("debounce", mm0);
  endtask

  task automatic test_levels();
    int mm0, f0, exp_lvl;
    mm0 = mm_cnt;
    clear_obs();
    step(10'($urandom_range(1, 799)), 10'($urandom_range(0, 470)), 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL start_running got=%b exp=1", running); end
    f0 = frame_idx;
    for (int f = 1; f <= 20; f++) begin
      run_frame(-1, 1'b0, 1'b0);
      exp_lvl = (f >= 12) ? 3 : (f >= 8) ? 2 : (f >= 4) ? 1 : 0;
      n_checks++;
      if (speed_level !== 2'(exp_lvl)) begin
        n_fail++; $display("FAIL level_frame%0d got=%0d exp=%0d", f, speed_level, exp_lvl);
      end
    end
    n_checks++;
    if (obs_obs !== 20) begin n_fail++; $display("FAIL obstacle_count got=%0d exp=20", obs_obs); end
    n_checks++;
    if (t20_frames.size() == 0 || t20_frames[0] !== f0) begin
      n_fail++; $display("FAIL first_tick_after_reset_20hz got=%0d pulses exp first in frame %0d", t20_frames.size(), f0);
    end
    check_model("levels", mm0);
  endtask

  task automatic test_same_cycle();
    int mm0;
    mm0 = mm_cnt;
    clear_obs();
    step(10'd3, 10'd200, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL over_wins got=%b exp=0", running); end
    for (int f = 0; f < 3; f++) run_frame(-1, 1'b0, 1'b0);
    n_checks++;
    if (obs60 !== 3 || obs_obs !== 0) begin
      n_fail++; $display("FAIL idle_ticks got=%0d/%0d exp=3/0", obs60, obs_obs);
    end
    n_checks++;
    if (speed_level !== 2'd3) begin n_fail++; $display("FAIL level_hold got=%0d exp=3", speed_level); end
    check_model("same_cycle", mm0);
  endtask

  task automatic test_restart();
    int mm0;
    mm0 = mm_cnt;
    step(10'd9, 10'd100, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (speed_level !== 2'd0 || running !== 1'b1) begin
      n_fail++; $display("FAIL restart got=lvl%0d run%b exp=lvl0 run1", speed_level, running);
    end
    for (int f = 0; f < LF - 1; f++) run_frame(-1, 1'b0, 1'b0);
    n_checks++;
    if (speed_level !== 2'd0) begin n_fail++; $display("FAIL restart_pre_inc got=%0d exp=0", speed_level); end
    run_frame(-1, 1'b0, 1'b0);
    n_checks++;
    if (speed_level !== 2'd1) begin n_fail++; $display("FAIL restart_inc got=%0d exp=1", speed_level); end
    check_model("restart", mm0);
  endtask

  task automatic test_random();
    int mm0;
    mm0 = mm_cnt;
    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(0, FRAME_LINES - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end
    check_model("random", mm0);
  endtask

  initial begin
    rst_n = 1'b0; hpos = 10'd0; vpos = 10'd0;
    game_start_pulse = 1'b0; game_over_pulse = 1'b0;
    frame_idx = 0;
    clear_obs();
    test_reset();
    test_frame_tick();
    test_20hz();
    test_debounce();
    test_levels();
    test_same_cycle();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
